pop_regen_mutate: RTL

//  GA stage directly downstream of parent selection. Takes the selected parent set (sel_pop) and rebuilds a full

---
 rtl/ga_pkg.sv | 32 +++
 rtl/ga_lfsr16.sv | 27 ++
 rtl/pop_regen_mutate.sv | 135 +++++++++++++
 3 files changed

// File: rtl/ga_pkg.sv
// Shared GA constants, controller state encoding and small LFSR/index helpers.
package ga_pkg;
    localparam int unsigned N_CITIES = 15;
    localparam int unsigned CITY_W   = 5;
    localparam int unsigned GENE_W   = N_CITIES * CITY_W;
    localparam int unsigned N_SEL    = 20;
    localparam int unsigned N_CHILD  = 5;
    localparam int unsigned POP_SIZE = N_SEL * N_CHILD;
    localparam int unsigned P_W      = $clog2(N_SEL);
    localparam int unsigned C_W      = $clog2(N_CHILD);

    localparam logic [15:0] LFSR_SEED_DEF = 16'hACE1;
    // Bit indices of the x^16+x^14+x^13+x^11 feedback taps.
    localparam int unsigned LFSR_TAP0 = 15;
    localparam int unsigned LFSR_TAP1 = 13;
    localparam int unsigned LFSR_TAP2 = 12;
    localparam int unsigned LFSR_TAP3 = 10;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StMutate = 2'd1,
        StDone   = 2'd2
    } state_e;

    function automatic logic [15:0] lfsr16_next(input logic [15:0] v);
        return {v[14:0], v[LFSR_TAP0] ^ v[LFSR_TAP1] ^ v[LFSR_TAP2] ^ v[LFSR_TAP3]};
    endfunction

    function automatic logic [3:0] fold_idx(input logic [3:0] r);
        return (r >= 4'(N_CITIES)) ? r - 4'(N_CITIES) : r;
    endfunction
endpackage

// File: rtl/ga_lfsr16.sv
// 16-bit Fibonacci LFSR that steps only when adv is high; reset loads SEED.
module ga_lfsr16
    import ga_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEF
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] q
);
    logic [15:0] q_q, q_d;

    always_comb begin
        q_d = adv ? lfsr16_next(q_q) : q_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= SEED;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;
endmodule

// File: rtl/pop_regen_mutate.sv
// Rebuilds the population: each parent yields one elite copy and N_CHILD-1 swap mutants.
// Defining PERM_CHECK_EN adds a sticky parent-permutation checker on perm_err.
module pop_regen_mutate
    import ga_pkg::*;
#(
    parameter logic [15:0] LFSR_SEED = LFSR_SEED_DEF
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [N_SEL*GENE_W-1:0]    sel_pop,
    output logic [POP_SIZE*GENE_W-1:0] new_pop,
    output logic                       busy,
    output logic                       done,
    output logic                       perm_err
);
    localparam logic [P_W-1:0] P_LAST = P_W'(N_SEL - 1);
    localparam logic [C_W-1:0] C_LAST = C_W'(N_CHILD - 1);

    state_e                     state_q, state_d;
    logic [P_W-1:0]             p_q, p_d;
    logic [C_W-1:0]             c_q, c_d;
    logic [N_SEL*GENE_W-1:0]    par_q, par_d;
    logic [POP_SIZE*GENE_W-1:0] new_pop_q;
    logic [15:0]                lfsr_q;
    logic [7:0]                 unused_lfsr;
    logic                       mutate;
    logic [GENE_W-1:0]          parent, child;
    logic [3:0]                 idx_a, idx_b;
    int unsigned                slot;

    assign mutate = (state_q == StMutate);

    ga_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk  (clk),
        .rst_n(rst_n),
        .adv  (mutate),
        .q    (lfsr_q)
    );
    assign unused_lfsr = lfsr_q[15:8];

    always_comb begin
        parent = par_q[32'(p_q) * GENE_W +: GENE_W];
        idx_a  = fold_idx(lfsr_q[3:0]);
        idx_b  = fold_idx(lfsr_q[7:4]);
        slot   = 32'(p_q) * N_CHILD + 32'(c_q);
        child  = parent;
        // Elite copy on c==0; a==b naturally degenerates to an unchanged copy.
        if (c_q != '0) begin
            child[32'(idx_a) * CITY_W +: CITY_W] = parent[32'(idx_b) * CITY_W +: CITY_W];
            child[32'(idx_b) * CITY_W +: CITY_W] = parent[32'(idx_a) * CITY_W +: CITY_W];
        end
    end

    always_comb begin
        state_d = state_q;
        p_d     = p_q;
        c_d     = c_q;
        par_d   = par_q;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    par_d   = sel_pop;
                    p_d     = '0;
                    c_d     = '0;
                    state_d = StMutate;
                end
            end
            StMutate: begin
                if (c_q == C_LAST) begin
                    c_d = '0;
                    if (p_q == P_LAST) begin
                        state_d = StDone;
                    end else begin
                        p_d = p_q + 1'b1;
                    end
                end else begin
                    c_d = c_q + 1'b1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= StIdle;
            p_q       <= '0;
            c_q       <= '0;
            par_q     <= '0;
            new_pop_q <= '0;
        end else begin
            state_q <= state_d;
            p_q     <= p_d;
            c_q     <= c_d;
            par_q   <= par_d;
            if (mutate) begin
                new_pop_q[slot * GENE_W +: GENE_W] <= child;
            end
        end
    end

    assign new_pop = new_pop_q;
    assign busy    = (state_q != StIdle);
    assign done    = (state_q == StDone);

`ifdef PERM_CHECK_EN
    logic [2**CITY_W-1:0]          seen;
    logic [2**CITY_W-N_CITIES-1:0] unused_seen;
    logic                          perm_ok;
    logic                          perm_err_q;

    // N_CITIES genes covering all N_CITIES legal values implies a permutation.
    always_comb begin
        seen = '0;
        for (int unsigned g = 0; g < N_CITIES; g++) begin
            seen[parent[g * CITY_W +: CITY_W]] = 1'b1;
        end
    end
    assign perm_ok     = &seen[N_CITIES-1:0];
    assign unused_seen = seen[2**CITY_W-1:N_CITIES];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perm_err_q <= 1'b0;
        end else if (mutate && (c_q == '0) && !perm_ok) begin
            perm_err_q <= 1'b1;
        end
    end
    assign perm_err = perm_err_q;
`else
    assign perm_err = 1'b0;
`endif
endmodule
